// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: bundle between the ID/EX register, the pipeline control and
// the EX result mux for the RV32M multiply/divide unit.
//   inst_i, reg1_i, reg2_i  instruction and rs1/rs2 operands from ID/EX
//   reg_waddr_i, reg_we_i   destination register and write request
//   flush_i                 pipeline flush (taken branch/jump)
//   stall_o                 combinational hold for PC, IF/ID and ID/EX
//   busy_o                  registered "operation in flight"
//   wdata_o, waddr_o, we_o  one-cycle result toward EX/MEM
interface ex_muldiv_if;
  logic [31:0] inst_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  reg_waddr_i;
  logic        reg_we_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic [31:0] wdata_o;
  logic [4:0]  waddr_o;
  logic        we_o;

  modport slave (
    input  inst_i, reg1_i, reg2_i, reg_waddr_i, reg_we_i, flush_i,
    output stall_o, busy_o, wdata_o, waddr_o, we_o
  );

  modport master (
    output inst_i, reg1_i, reg2_i, reg_waddr_i, reg_we_i, flush_i,
    input  stall_o, busy_o, wdata_o, waddr_o, we_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: execute-stage RV32M multiply/divide unit.
// MUL family completes in one extra cycle; divides use a restoring
// shift-subtract loop (one quotient bit per cycle, DIV_ITERS iterations).
// Divide-by-zero and signed overflow are resolved at issue.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  ex_muldiv_if.slave (operands in; stall/busy/result out)
// Optional build macro: MULDIV_EARLY_OUT_EN -- divides with
// |divisor| > |dividend| finish at issue with quotient 0 and
// remainder equal to the dividend.
module ex_muldiv #(
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic       clk,
  input  logic       rst,
  ex_muldiv_if.slave bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;
  localparam logic [6:0]  OPC_OP    = 7'b0110011;
  localparam logic [6:0]  F7_MULDIV = 7'b0000001;
  localparam logic [XLEN-1:0] INT_MIN = 32'h80000000;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic              we_lat_q, we_lat_d;
  logic [XLEN-1:0]   a_q, a_d;       // multiplicand, or dividend shifting into quotient
  logic [XLEN-1:0]   b_q, b_d;       // multiplier, or divisor magnitude
  logic [XLEN-1:0]   rem_q, rem_d;   // partial remainder
  logic              neg_q_q, neg_q_d;
  logic              neg_r_q, neg_r_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [4:0]        waddr_q, waddr_d;
  logic              we_q, we_d;
  logic              busy_q;

  // Decode of the instruction sitting in ID/EX
  logic            start_c;
  logic [2:0]      funct3_c;
  logic            sdiv_c;
  logic [XLEN-1:0] abs1_c, abs2_c;

  assign start_c  = (bus.inst_i[6:0] == OPC_OP) && (bus.inst_i[31:25] == F7_MULDIV);
  assign funct3_c = bus.inst_i[14:12];
  assign sdiv_c   = ~funct3_c[0];
  assign abs1_c   = (sdiv_c && bus.reg1_i[XLEN-1]) ? -bus.reg1_i : bus.reg1_i;
  assign abs2_c   = (sdiv_c && bus.reg2_i[XLEN-1]) ? -bus.reg2_i : bus.reg2_i;

  // Product of the latched operands; MUL/MULH sign-extend both, MULHSU only rs1
  logic signed [XLEN:0]     ma_c, mb_c;
  logic signed [2*XLEN+1:0] prod_c;

  assign ma_c   = $signed({(f3_q[1:0] != 2'b11) & a_q[XLEN-1], a_q});
  assign mb_c   = $signed({~f3_q[1] & b_q[XLEN-1], b_q});
  assign prod_c = 66'(ma_c) * 66'(mb_c);

  // One restoring-divide step: shift in the next dividend bit, try subtract
  logic [XLEN:0]   rs_c;
  logic [XLEN+1:0] diff_c;
  logic            qbit_c;
  logic [XLEN-1:0] rem_n_c, quo_n_c, q_fix_c, r_fix_c;

  assign rs_c    = {rem_q, a_q[XLEN-1]};
  assign diff_c  = {1'b0, rs_c} - {2'b00, b_q};
  assign qbit_c  = ~diff_c[XLEN+1];
  assign rem_n_c = qbit_c ? diff_c[XLEN-1:0] : rs_c[XLEN-1:0];
  assign quo_n_c = {a_q[XLEN-2:0], qbit_c};
  assign q_fix_c = neg_q_q ? -quo_n_c : quo_n_c;
  assign r_fix_c = neg_r_q ? -rem_n_c : rem_n_c;

  logic unused_c;
  assign unused_c = ^{bus.inst_i[24:15], bus.inst_i[11:7], diff_c[XLEN], prod_c[2*XLEN+1:2*XLEN]};

  // Stall covers the issue cycle and every MUL/DIV cycle; a flush releases it at once
  assign bus.stall_o = ~rst & ~bus.flush_i &
                       (((state_q == S_IDLE) & start_c) | (state_q == S_MUL) | (state_q == S_DIV));
  assign bus.busy_o  = busy_q;
  assign bus.wdata_o = wdata_q;
  assign bus.waddr_o = waddr_q;
  assign bus.we_o    = we_q;

  // Next-state and result logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    we_lat_d = we_lat_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    wdata_d  = wdata_q;
    waddr_d  = waddr_q;
    we_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_c && !bus.flush_i) begin
          f3_d     = funct3_c;
          rd_d     = bus.reg_waddr_i;
          we_lat_d = bus.reg_we_i;
          cnt_d    = '0;
          rem_d    = '0;
          if (!funct3_c[2]) begin
            a_d     = bus.reg1_i;
            b_d     = bus.reg2_i;
            neg_q_d = 1'b0;
            neg_r_d = 1'b0;
            state_d = S_MUL;
          end else begin
            a_d     = abs1_c;
            b_d     = abs2_c;
            neg_q_d = sdiv_c & (bus.reg1_i[XLEN-1] ^ bus.reg2_i[XLEN-1]);
            neg_r_d = sdiv_c & bus.reg1_i[XLEN-1];
            if (bus.reg2_i == '0) begin
              state_d = S_DONE;
              wdata_d = funct3_c[1] ? bus.reg1_i : '1;
              waddr_d = bus.reg_waddr_i;
              we_d    = bus.reg_we_i;
            end else if (sdiv_c && (bus.reg1_i == INT_MIN) && (bus.reg2_i == '1)) begin
              state_d = S_DONE;
              wdata_d = funct3_c[1] ? '0 : INT_MIN;
              waddr_d = bus.reg_waddr_i;
              we_d    = bus.reg_we_i;
            end
`ifdef MULDIV_EARLY_OUT_EN
            else if (abs2_c > abs1_c) begin
              state_d = S_DONE;
              wdata_d = funct3_c[1] ? bus.reg1_i : '0;
              waddr_d = bus.reg_waddr_i;
              we_d    = bus.reg_we_i;
            end
`endif
            else begin
              state_d = S_DIV;
            end
          end
        end
      end

      S_MUL: begin
        if (bus.flush_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          wdata_d = (f3_q[1:0] == 2'b00) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
          waddr_d = rd_q;
          we_d    = we_lat_q;
        end
      end

      S_DIV: begin
        if (bus.flush_i) begin
          state_d = S_IDLE;
        end else begin
          a_d   = quo_n_c;
          rem_d = rem_n_c;
          cnt_d = cnt_q + CNT_W'(1);
          // Last step: register the sign-corrected quotient or remainder
          if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
            state_d = S_DONE;
            wdata_d = f3_q[1] ? r_fix_c : q_fix_c;
            waddr_d = rd_q;
            we_d    = we_lat_q;
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      we_lat_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      wdata_q  <= '0;
      waddr_q  <= '0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      we_lat_q <= we_lat_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      wdata_q  <= wdata_d;
      waddr_q  <= waddr_d;
      we_q     <= we_d;
      busy_q   <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed bench for ex_muldiv. A cycle-count model derived
// from RV32M arithmetic and the documented latencies predicts stall/busy/we
// and the written result every cycle; each directed vector also pins the
// model against a hand-computed result and latency.
module tb_ex_muldiv;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_muldiv_if bus ();

  ex_muldiv #(.DIV_ITERS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h00000013;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int EO_LAT = 2;
`else
  localparam int EO_LAT = 34;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    logic            ovf;
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    case (f3)
      3'b000: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp[31:0]; end
      3'b001: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp[63:32]; end
      3'b010: begin sp = longint'($signed(a)) * longint'({32'h0, b}); return sp[63:32]; end
      3'b011: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
      3'b100: return (b == 0) ? 32'hFFFFFFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'b110: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycles from the instruction entering EX to the we_o cycle, inclusive
  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub;
    logic        sg;
    if (!f3[2]) return 3;
    if (b == 0) return 2;
    sg = !f3[0];
    if (sg && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
    ua = (sg && a[31]) ? -a : a;
    ub = (sg && b[31]) ? -b : b;
`ifdef MULDIV_EARLY_OUT_EN
    if (ub > ua) return 2;
`else
    if (ub > ua) return 34;
`endif
    return 34;
  endfunction

  // Compare process: predicts outputs from the model every cycle
  initial begin : compare
    bit          m_busy = 1'b0;
    bit          m_rstd = 1'b0;
    int          m_left = 0;
    logic [31:0] m_res  = '0;
    logic [4:0]  m_rd   = '0;
    bit          m_we   = 1'b0;
    bit          is_m;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("stall_in_reset", 32'(bus.stall_o), 32'd0);
        m_busy = 1'b0;
        m_rstd = 1'b1;
      end else begin
        is_m = (bus.inst_i[6:0] == 7'b0110011) && (bus.inst_i[31:25] == 7'b0000001);
        if (!m_busy) begin
          chk("stall_idle", 32'(bus.stall_o), 32'(is_m && !bus.flush_i));
          chk("we_idle", 32'(bus.we_o), 32'd0);
          chk("busy_idle", 32'(bus.busy_o), 32'd0);
          if (m_rstd) begin
            chk("wdata_after_reset", bus.wdata_o, 32'd0);
            chk("waddr_after_reset", 32'(bus.waddr_o), 32'd0);
          end
          if (is_m && !bus.flush_i) begin
            m_busy = 1'b1;
            m_left = ref_lat(bus.inst_i[14:12], bus.reg1_i, bus.reg2_i) - 2;
            m_res  = ref_result(bus.inst_i[14:12], bus.reg1_i, bus.reg2_i);
            m_rd   = bus.reg_waddr_i;
            m_we   = bus.reg_we_i;
          end
        end else if (m_left > 0) begin
          chk("stall_running", 32'(bus.stall_o), 32'(!bus.flush_i));
          chk("we_running", 32'(bus.we_o), 32'd0);
          chk("busy_running", 32'(bus.busy_o), 32'd1);
          if (bus.flush_i) m_busy = 1'b0;
          else m_left--;
        end else begin
          chk("stall_done", 32'(bus.stall_o), 32'd0);
          chk("busy_done", 32'(bus.busy_o), 32'd1);
          chk("we_done", 32'(bus.we_o), 32'(m_we));
          chk("wdata_done", bus.wdata_o, m_res);
          chk("waddr_done", 32'(bus.waddr_o), 32'(m_rd));
          m_busy = 1'b0;
        end
        m_rstd = 1'b0;
      end
    end
  end

  // Present one M instruction as ID/EX would: hold it while stall_o is high.
  // ev_kind 1 pulses flush_i, 2 pulses rst, in cycle ev_at after entry.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic we, input logic [31:0] exp_v,
                        input int exp_l, input int ev_kind, input int ev_at);
    int   idx;
    logic st;
    bit   fin;
    chk("pin_result", ref_result(f3, a, b), exp_v);
    chk("pin_latency", 32'(ref_lat(f3, a, b)), 32'(exp_l));
    bus.inst_i      = {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
    bus.reg1_i      = a;
    bus.reg2_i      = b;
    bus.reg_waddr_i = rd;
    bus.reg_we_i    = we;
    idx = 0;
    fin = 1'b0;
    while (!fin) begin
      bus.flush_i = (ev_kind == 1) && (idx == ev_at);
      rst         = (ev_kind == 2) && (idx == ev_at);
      @(negedge clk);
      st = bus.stall_o;
      @(posedge clk);
      #1;
      idx++;
      if (!st) fin = 1'b1;
      else if (idx > 100) begin
        chk("stall_timeout", 32'(idx), 32'(exp_l));
        fin = 1'b1;
      end
    end
    bus.flush_i = 1'b0;
    rst         = 1'b0;
    bus.inst_i  = NOP;
    bus.reg_we_i = 1'b0;
  endtask

  initial begin : stim
    rst             = 1'b1;
    bus.inst_i      = NOP;
    bus.reg1_i      = '0;
    bus.reg2_i      = '0;
    bus.reg_waddr_i = '0;
    bus.reg_we_i    = 1'b0;
    bus.flush_i     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    //      f3      rs1           rs2           rd  we  expected      lat
    run_op(3'b000, 32'd7,        32'hFFFFFFFD, 5,  1, 32'hFFFFFFEB, 3,  0, 0);
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 6,  1, 32'hFFFFFFFE, 3,  0, 0);
    run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 7,  1, 32'hFFFFFFFF, 3,  0, 0);
    run_op(3'b001, 32'h80000000, 32'h80000000, 8,  1, 32'h40000000, 3,  0, 0);
    run_op(3'b100, 32'hFFFFFFEC, 32'd6,        10, 1, 32'hFFFFFFFD, 34, 0, 0);
    run_op(3'b110, 32'hFFFFFFEC, 32'd6,        11, 1, 32'hFFFFFFFE, 34, 0, 0);
    run_op(3'b101, 32'd100,      32'd7,        12, 1, 32'd14,       34, 0, 0);
    run_op(3'b111, 32'd100,      32'd7,        13, 1, 32'd2,        34, 0, 0);
    run_op(3'b101, 32'd123,      32'd0,        14, 1, 32'hFFFFFFFF, 2,  0, 0);
    run_op(3'b111, 32'd123,      32'd0,        15, 1, 32'd123,      2,  0, 0);
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 16, 1, 32'h80000000, 2,  0, 0);
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 17, 1, 32'd0,        2,  0, 0);
    run_op(3'b100, 32'd7,        32'hFFFFFFFE, 18, 1, 32'hFFFFFFFD, 34, 0, 0);
    run_op(3'b110, 32'd7,        32'hFFFFFFFE, 19, 1, 32'd1,        34, 0, 0);
    run_op(3'b101, 32'd5,        32'd9,        20, 1, 32'd0,        EO_LAT, 0, 0);
    run_op(3'b111, 32'd5,        32'd9,        21, 1, 32'd5,        EO_LAT, 0, 0);
    run_op(3'b110, 32'hFFFFFFF9, 32'd100,      22, 1, 32'hFFFFFFF9, EO_LAT, 0, 0);
    run_op(3'b000, 32'd3,        32'd4,        0,  1, 32'd12,       3,  0, 0);
    run_op(3'b000, 32'd5,        32'd5,        9,  0, 32'd25,       3,  0, 0);
    // Flush at divide counter 10, flush during DONE, reset during MUL
    run_op(3'b100, 32'hFFFFFFEC, 32'd6,        23, 1, 32'hFFFFFFFD, 34, 1, 11);
    run_op(3'b101, 32'd123,      32'd0,        24, 1, 32'hFFFFFFFF, 2,  1, 1);
    run_op(3'b000, 32'd7,        32'd9,        25, 1, 32'd63,       3,  2, 1);
    run_op(3'b011, 32'h00010000, 32'h00010000, 26, 1, 32'd1,        3,  0, 0);

    // Non-M R-type (ADD) must be ignored
    bus.inst_i      = 32'h002081B3;
    bus.reg1_i      = 32'd1;
    bus.reg2_i      = 32'd2;
    bus.reg_waddr_i = 5'd3;
    bus.reg_we_i    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.inst_i   = NOP;
    bus.reg_we_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
